// File: rtl/esp32_mem_arbiter_if.sv
// esp32_mem_arbiter_if: bundles the SPI pending-op pulses, the host held-request
// handshake, the shared buffer port and the grant statistics of esp32_mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding
// system (SPI protocol processor, host bus, memory).
interface esp32_mem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              spi_wr_en;
  logic [2:0]        spi_wr_space;
  logic [23:0]       spi_wr_addr;
  logic [7:0]        spi_wr_data;
  logic              spi_rd_req;
  logic [2:0]        spi_rd_space;
  logic [23:0]       spi_rd_addr;
  logic              spi_rd_valid;
  logic [7:0]        spi_rd_data;
  logic              spi_ovf;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack;
  logic [7:0]        host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic [15:0]       spi_grant_cnt;
  logic [15:0]       host_grant_cnt;

  modport slave (
    input  spi_wr_en, spi_wr_space, spi_wr_addr, spi_wr_data,
    input  spi_rd_req, spi_rd_space, spi_rd_addr,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output spi_rd_valid, spi_rd_data, spi_ovf,
    output host_ack, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output spi_grant_cnt, host_grant_cnt
  );

  modport master (
    output spi_wr_en, spi_wr_space, spi_wr_addr, spi_wr_data,
    output spi_rd_req, spi_rd_space, spi_rd_addr,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  spi_rd_valid, spi_rd_data, spi_ovf,
    input  host_ack, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  spi_grant_cnt, host_grant_cnt
  );
endinterface

// File: rtl/esp32_mem_arbiter.sv
// esp32_mem_arbiter: shares one single-port, synchronous-read buffer (SPACE 0)
// between the ESP32 SPI protocol processor and the Apple II host requester.
// SPI ops are unstallable pulses captured in one-entry WR/RD pending slots; the
// host uses held-request / pulsed-ack. Arbitration is WR > RD > host, except the
// host wins once it has watched STARVE_MAX consecutive SPI grants. One access is
// in flight at a time: IDLE (grant) -> ACCESS (mem_en) -> RETIRE (capture).
// Optional grant statistics are built when ESP32_MEM_ARB_STATS_EN is defined;
// otherwise both counter ports are tied to zero.
module esp32_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst_n,
  esp32_mem_arbiter_if.slave bus
);

  localparam int              SC_W       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RETIRE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WR   = 2'd1,
    SRC_RD   = 2'd2,
    SRC_HOST = 2'd3
  } src_t;

  state_t            state;
  src_t              cur_src;
  logic              cur_nz;
  logic              cur_we;

  logic              wr_pend;
  logic              wr_nz;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              rd_pend;
  logic              rd_nz;
  logic [ADDR_W-1:0] rd_addr;

  logic [SC_W-1:0]   starve_cnt;

  logic              host_cand;
  logic              grant_wr;
  logic              grant_rd;
  logic              grant_host;

  // Only the low ADDR_W bits of the 24-bit SPI addresses reach the buffer.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.spi_wr_addr[23:ADDR_W], bus.spi_rd_addr[23:ADDR_W]};

  // Pick this cycle's winner; the host is ignored during its own ack cycle.
  always_comb begin
    host_cand  = bus.host_req && !bus.host_ack;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    grant_host = 1'b0;
    if (state == IDLE) begin
      if (host_cand && (starve_cnt == STARVE_LIM)) begin
        grant_host = 1'b1;
      end else if (wr_pend) begin
        grant_wr = 1'b1;
      end else if (rd_pend) begin
        grant_rd = 1'b1;
      end else if (host_cand) begin
        grant_host = 1'b1;
      end
    end
  end

  // Capture SPI pulses into their slots; a pulse meeting a full, ungranted slot is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend     <= 1'b0;
      wr_nz       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 8'h00;
      rd_pend     <= 1'b0;
      rd_nz       <= 1'b0;
      rd_addr     <= '0;
      bus.spi_ovf <= 1'b0;
    end else begin
      if (grant_wr) begin
        wr_pend <= 1'b0;
      end
      if (bus.spi_wr_en) begin
        if (wr_pend && !grant_wr) begin
          bus.spi_ovf <= 1'b1;
        end else begin
          wr_pend <= 1'b1;
          wr_nz   <= (bus.spi_wr_space != 3'd0);
          wr_addr <= bus.spi_wr_addr[ADDR_W-1:0];
          wr_data <= bus.spi_wr_data;
        end
      end
      if (grant_rd) begin
        rd_pend <= 1'b0;
      end
      if (bus.spi_rd_req) begin
        if (rd_pend && !grant_rd) begin
          bus.spi_ovf <= 1'b1;
        end else begin
          rd_pend <= 1'b1;
          rd_nz   <= (bus.spi_rd_space != 3'd0);
          rd_addr <= bus.spi_rd_addr[ADDR_W-1:0];
        end
      end
    end
  end

  // Track how many SPI grants in a row the waiting host has watched go by.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!bus.host_req || grant_host) begin
      starve_cnt <= '0;
    end else if ((grant_wr || grant_rd) && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  // Access sequencer: register the winner's memory op, strobe it, then retire the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cur_src          <= SRC_NONE;
      cur_nz           <= 1'b0;
      cur_we           <= 1'b0;
      bus.mem_en       <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= 8'h00;
      bus.spi_rd_valid <= 1'b0;
      bus.spi_rd_data  <= 8'h00;
      bus.host_ack     <= 1'b0;
      bus.host_rdata   <= 8'h00;
    end else begin
      bus.spi_rd_valid <= 1'b0;
      bus.host_ack     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            bus.mem_en    <= !wr_nz;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= wr_addr;
            bus.mem_wdata <= wr_data;
            cur_src       <= SRC_WR;
            cur_nz        <= wr_nz;
            cur_we        <= 1'b1;
            state         <= ACCESS;
          end else if (grant_rd) begin
            bus.mem_en    <= !rd_nz;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= rd_addr;
            cur_src       <= SRC_RD;
            cur_nz        <= rd_nz;
            cur_we        <= 1'b0;
            state         <= ACCESS;
          end else if (grant_host) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.host_we;
            bus.mem_addr  <= bus.host_addr;
            bus.mem_wdata <= bus.host_wdata;
            cur_src       <= SRC_HOST;
            cur_nz        <= 1'b0;
            cur_we        <= bus.host_we;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          state      <= RETIRE;
        end
        RETIRE: begin
          case (cur_src)
            SRC_RD: begin
              bus.spi_rd_valid <= 1'b1;
              bus.spi_rd_data  <= cur_nz ? 8'hFF : bus.mem_rdata;
            end
            SRC_HOST: begin
              bus.host_ack <= 1'b1;
              if (!cur_we) begin
                bus.host_rdata <= bus.mem_rdata;
              end
            end
            default: begin
            end
          endcase
          cur_src <= SRC_NONE;
          state   <= IDLE;
        end
        default: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          cur_src    <= SRC_NONE;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef ESP32_MEM_ARB_STATS_EN
  logic [15:0] spi_cnt;
  logic [15:0] host_cnt;

  // Count grants per requester, saturating so a long run never wraps to a small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_cnt  <= 16'h0000;
      host_cnt <= 16'h0000;
    end else begin
      if ((grant_wr || grant_rd) && (spi_cnt != 16'hFFFF)) begin
        spi_cnt <= spi_cnt + 16'h0001;
      end
      if (grant_host && (host_cnt != 16'hFFFF)) begin
        host_cnt <= host_cnt + 16'h0001;
      end
    end
  end

  assign bus.spi_grant_cnt  = spi_cnt;
  assign bus.host_grant_cnt = host_cnt;
`else
  assign bus.spi_grant_cnt  = 16'h0000;
  assign bus.host_grant_cnt = 16'h0000;
`endif

endmodule

// File: doc/esp32_mem_arbiter.md
# esp32_mem_arbiter

- Shares one single-port, synchronous-read 256-byte buffer (SPACE 0) between the ESP32 SPI protocol processor and a host-side (Apple II bus) requester.
- SPI-side operations are single-cycle pulses that cannot be stalled, so the block captures them in one-entry pending slots.
- The host side uses a held-request / pulsed-ack handshake.
- Arbitration is SPI-priority with a starvation bound for the host; at most one memory access is in flight at a time.

## Interface

Parameters:
- ADDR_W, default 8: memory address width; the buffer depth is 2**ADDR_W.
- STARVE_MAX, default 4: number of consecutive SPI grants allowed while host_req is pending.

Ports:
- clk  in  1  system clock (54 MHz). One clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- spi_wr_en  in  1  single-cycle write pulse.
- spi_wr_space  in  3  address space of the write.
- spi_wr_addr  in  24  write address; bits [ADDR_W-1:0] are used.
- spi_wr_data  in  8  write data.
- spi_rd_req  in  1  single-cycle read pulse.
- spi_rd_space  in  3  address space of the read.
- spi_rd_addr  in  24  read address; bits [ADDR_W-1:0] are used.
- spi_rd_valid  out  1  one-cycle pulse; spi_rd_data is valid in that cycle.
- spi_rd_data  out  8  read data.
- spi_ovf  out  1  sticky flag: an SPI op was dropped because its pending slot was full.
- host_req  in  1  held high, with host_we/host_addr/host_wdata stable, until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  8  host write data.
- host_ack  out  1  one-cycle completion pulse; host_rdata is valid in that cycle for reads.
- host_rdata  out  8  host read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data; valid the cycle after mem_en with mem_we=0.
- spi_grant_cnt  out  16  SPI grant count (see Configuration).
- host_grant_cnt  out  16  host grant count (see Configuration).

## Operation

Pending slots:
- There are two SPI pending slots, WR and RD. A pulse fills its slot at the end of the pulse cycle.
- A pulse arriving while its slot is full is dropped and sets spi_ovf. spi_ovf clears only on reset.
- A slot frees at the end of the cycle the arbiter grants it. A pulse in that same cycle is accepted into the slot, not dropped.
- Non-zero space writes: consumed on grant, no memory access, no response.
- Non-zero space reads: consumed on grant, no memory access; spi_rd_valid pulses with spi_rd_data=8'hFF at the normal latency.

FSM states: IDLE, ACCESS, RETIRE.
- IDLE: arbitrate among pending WR, pending RD and host_req. Register mem_* outputs and the winner; go to ACCESS. With no candidate, stay in IDLE.
- Arbitration order: WR slot, then RD slot, then host. Exception: when starve_cnt == STARVE_MAX and host_req=1, the host wins.
- WR beats RD so that read-after-write from SPI is coherent.
- IDLE ignores host_req in the cycle host_ack=1. The host must drop host_req the cycle after ack.
- ACCESS: mem_en=1 (suppressed for non-zero-space SPI ops). Go to RETIRE.
- RETIRE: capture mem_rdata, or 8'hFF for non-zero-space reads. Register spi_rd_valid or host_ack for the next cycle. Go to IDLE.
- Host writes also pulse host_ack.
- starve_cnt: increments, saturating at STARVE_MAX, on each SPI grant while host_req=1. Clears on a host grant or whenever host_req=0.
- Reset mid-operation: all state clears, pending ops are lost, and no ack or valid is emitted afterward.

## Timing

- Reset values: all outputs 0 (mem_*, spi_rd_valid, spi_rd_data, spi_ovf, host_ack, host_rdata, both counters). State IDLE, slots empty, starve_cnt 0.
- Uncontended SPI read: spi_rd_req in cycle 0; IDLE grant in cycle 1; mem_en in cycle 2; RETIRE in cycle 3; spi_rd_valid in cycle 4. Latency is exactly 4 clk.
- Uncontended host access: host_req first high in cycle 0 with state IDLE; host_ack in cycle 3.
- Throughput: one access per 3 clk.
- SPI byte spacing is ≥8 sclk, which is far more than 3 clk, so a slot overrun only occurs under sustained host contention.
- All outputs are registered.

## Configuration

Macro ESP32_MEM_ARB_STATS_EN:
- Defined: spi_grant_cnt and host_grant_cnt count grants (including non-zero-space SPI ops), each saturating at 16'hFFFF, cleared by reset.
- Undefined: both ports are tied to 16'h0000 and no counter logic is built.

## Test plan

- SPI write 8'hA5 to addr 0x10 (space 0), then SPI read 0x10 → spi_rd_valid exactly 4 clk after spi_rd_req, data 8'hA5.
- spi_wr_en and spi_rd_req in the same cycle, both addr 0x20, wdata 8'h3C → write issues first, then the read returns 8'h3C.
- SPI read with space 1 → mem_en never asserts; spi_rd_valid after 4 clk with data 8'hFF.
- host_req held (read 0x05) while SPI alternates WR/RD back-to-back, STARVE_MAX=4 → host granted after exactly 4 SPI grants, host_ack with the correct data, no spi_ovf.
- Host writes 8'h77 to 0x40 while SPI pulses two writes 1 clk apart during the host ACCESS → second pulse dropped, spi_ovf=1 and stays 1; memory 0x40 = 8'h77.
- Assert rst_n low during ACCESS of a host read → all outputs 0, host_ack never pulses; after release, a fresh host read completes normally. With ESP32_MEM_ARB_STATS_EN defined, host_grant_cnt counts from 0 again.
